clock_ctrl: RTL and testbench

- Mode and timing controller for the digital-clock counter chain.
- Divides the system clock into a 1 s tick and issues single-cycle increment enables to the seconds, minutes and hours counters, including carry sequencing from the counters' at-max flags.
- Runs a RUN / SET_HR / SET_MIN / SET_SEC state machine driven by two push-buttons, and produces a blink strobe for the field being set.

---
 rtl/clock_ctrl.sv | 130 +++++++++++++
 tb/tb_clock_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/clock_ctrl.sv
// clock_ctrl: mode and timing controller for the digital-clock counter chain.
//
// Divides clk into a 1 s tick and issues one-cycle increment enables to the
// seconds/minutes/hours counters (with carry from the at-max flags). It also runs
// the RUN -> SET_HR -> SET_MIN -> SET_SEC -> RUN mode machine from two buttons,
// and produces a blink strobe for the field being set.
//
// Ports:
//   clk         system clock, all state on posedge
//   reset       asynchronous, active-low clear of all state
//   btn_mode    raw mode button level (asynchronous)
//   btn_inc     raw increment button level (asynchronous)
//   sec_at_max  seconds counter holds 59
//   min_at_max  minutes counter holds 59
//   sec_inc     one-cycle increment enable, seconds counter
//   min_inc     one-cycle increment enable, minutes counter
//   hr_inc      one-cycle increment enable, hours counter
//   mode        00 RUN, 01 SET_HR, 10 SET_MIN, 11 SET_SEC
//   blink       display-blank strobe for the field being set, 0 in RUN
module clock_ctrl #(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       sec_at_max,
    input  logic       min_at_max,
    output logic       sec_inc,
    output logic       min_inc,
    output logic       hr_inc,
    output logic [1:0] mode,
    output logic       blink
);

    localparam int unsigned PreW = $clog2(TICK_DIV);
    localparam logic [PreW-1:0] PreLast = PreW'(TICK_DIV - 1);
    localparam logic [PreW-1:0] PreHalf = PreW'(TICK_DIV / 2 - 1);

    typedef enum logic [1:0] {
        StRun    = 2'b00,
        StSetHr  = 2'b01,
        StSetMin = 2'b10,
        StSetSec = 2'b11
    } mode_e;

    // Per button: [0] = s1, [1] = s2, [2] = s3 (delay for edge detect).
    logic [2:0]      mode_sync_q;
    logic [2:0]      inc_sync_q;
    mode_e           state_q, state_d;
    logic [PreW-1:0] presc_q, presc_d;
    logic            sec_inc_q, sec_inc_d;
    logic            min_inc_q, min_inc_d;
    logic            hr_inc_q, hr_inc_d;
    logic            blink_q, blink_d;

    logic mode_pulse;
    logic inc_pulse;
    logic presc_wrap;
    logic presc_half;

    assign mode_pulse = mode_sync_q[1] & ~mode_sync_q[2];
    assign inc_pulse  = inc_sync_q[1] & ~inc_sync_q[2];
    assign presc_wrap = (presc_q == PreLast);
    assign presc_half = (presc_q == PreHalf);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_sync_q <= '0;
            inc_sync_q  <= '0;
            state_q     <= StRun;
            presc_q     <= '0;
            sec_inc_q   <= 1'b0;
            min_inc_q   <= 1'b0;
            hr_inc_q    <= 1'b0;
            blink_q     <= 1'b0;
        end else begin
            mode_sync_q <= {mode_sync_q[1:0], btn_mode};
            inc_sync_q  <= {inc_sync_q[1:0], btn_inc};
            state_q     <= state_d;
            presc_q     <= presc_d;
            sec_inc_q   <= sec_inc_d;
            min_inc_q   <= min_inc_d;
            hr_inc_q    <= hr_inc_d;
            blink_q     <= blink_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_wrap ? '0 : presc_q + PreW'(1);
        sec_inc_d = 1'b0;
        min_inc_d = 1'b0;
        hr_inc_d  = 1'b0;
        blink_d   = blink_q;

        if (mode_pulse) begin
            // Mode advance takes priority; any coincident inc press or tick is dropped.
            state_d = mode_e'(state_q + 2'd1);
            presc_d = '0;
            blink_d = (state_d != StRun);
        end else begin
            unique case (state_q)
                StRun: begin
                    blink_d = 1'b0;
                    if (presc_wrap) begin
                        sec_inc_d = 1'b1;
                        min_inc_d = sec_at_max;
                        hr_inc_d  = sec_at_max & min_at_max;
                    end
                end
                StSetHr:  hr_inc_d  = inc_pulse;
                StSetMin: min_inc_d = inc_pulse;
                StSetSec: sec_inc_d = inc_pulse;
                default:  state_d   = StRun;
            endcase
            // Two toggles per prescaler period gives a blink period of TICK_DIV cycles.
            if (state_q != StRun && (presc_wrap || presc_half)) begin
                blink_d = ~blink_q;
            end
        end
    end

    assign sec_inc = sec_inc_q;
    assign min_inc = min_inc_q;
    assign hr_inc  = hr_inc_q;
    assign mode    = state_q;
    assign blink   = blink_q;

endmodule

// File: tb/tb_clock_ctrl.sv
// Directed bench for clock_ctrl with TICK_DIV = 10. Inputs are driven and outputs
// sampled on the falling clock edge. `since` counts rising edges since the last
// mode change or reset release, which equals the expected prescaler value.
module tb_clock_ctrl;

    logic       clk;
    logic       reset;
    logic       btn_mode;
    logic       btn_inc;
    logic       sec_at_max;
    logic       min_at_max;
    logic       sec_inc;
    logic       min_inc;
    logic       hr_inc;
    logic [1:0] mode;
    logic       blink;

    int checks;
    int errors;
    int since;

    clock_ctrl #(
        .TICK_DIV(10)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .sec_at_max(sec_at_max),
        .min_at_max(min_at_max),
        .sec_inc   (sec_inc),
        .min_inc   (min_inc),
        .hr_inc    (hr_inc),
        .mode      (mode),
        .blink     (blink)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (since=%0d, t=%0t)", tag, got, exp, since,
                     $time);
        end
    endtask

    // Advance one edge and check all outputs for a block sitting in mode m.
    // press marks an expected button increment: [2]=hr, [1]=min, [0]=sec.
    task automatic step_model(input logic [1:0] m, input logic [2:0] press);
        logic tk;
        logic bl;
        @(negedge clk);
        since++;
        tk = (m == 2'd0) && (since % 10 == 0);
        bl = (m != 2'd0) && ((since / 5) % 2 == 0);
        check("mode", mode, m);
        check("sec_inc", {1'b0, sec_inc}, {1'b0, tk | press[0]});
        check("min_inc", {1'b0, min_inc}, {1'b0, (tk & sec_at_max) | press[1]});
        check("hr_inc", {1'b0, hr_inc}, {1'b0, (tk & sec_at_max & min_at_max) | press[2]});
        check("blink", {1'b0, blink}, {1'b0, bl});
    endtask

    // Mode press held 5 edges, then 3 idle edges; advance lands on the 3rd edge.
    task automatic press_mode(input logic [1:0] m);
        logic [1:0] nx;
        nx = m + 2'd1;
        btn_mode = 1'b1;
        step_model(m, 3'b000);
        step_model(m, 3'b000);
        @(negedge clk);
        since = 0;
        check("mode_adv", mode, nx);
        check("blink_enter", {1'b0, blink}, {1'b0, nx != 2'd0});
        check("sec_at_adv", {1'b0, sec_inc}, 2'b00);
        step_model(nx, 3'b000);
        step_model(nx, 3'b000);
        btn_mode = 1'b0;
        repeat (3) step_model(nx, 3'b000);
    endtask

    // Inc press held 5 edges, then 3 idle edges; one enable expected on the 3rd edge.
    task automatic press_inc(input logic [1:0] m);
        logic [2:0] sel;
        case (m)
            2'd1:    sel = 3'b100;
            2'd2:    sel = 3'b010;
            2'd3:    sel = 3'b001;
            default: sel = 3'b000;
        endcase
        btn_inc = 1'b1;
        step_model(m, 3'b000);
        step_model(m, 3'b000);
        step_model(m, sel);
        step_model(m, 3'b000);
        step_model(m, 3'b000);
        btn_inc = 1'b0;
        repeat (3) step_model(m, 3'b000);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        since      = 0;
        reset      = 1'b1;
        btn_mode   = 1'b0;
        btn_inc    = 1'b0;
        sec_at_max = 1'b0;
        min_at_max = 1'b0;

        // Reset state.
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_mode", mode, 2'b00);
        check("rst_sec", {1'b0, sec_inc}, 2'b00);
        check("rst_min", {1'b0, min_inc}, 2'b00);
        check("rst_hr", {1'b0, hr_inc}, 2'b00);
        check("rst_blink", {1'b0, blink}, 2'b00);

        // Tick timing: sec_inc at edges 10, 20, 30 after release.
        reset = 1'b1;
        since = 0;
        repeat (35) step_model(2'd0, 3'b000);

        // Carry: seconds at max (tick at 40), then both at max (tick at 50).
        sec_at_max = 1'b1;
        repeat (10) step_model(2'd0, 3'b000);
        min_at_max = 1'b1;
        repeat (10) step_model(2'd0, 3'b000);
        sec_at_max = 1'b0;
        min_at_max = 1'b0;

        // Inc button ignored in RUN.
        press_inc(2'd0);

        // Mode cycling through all four states.
        press_mode(2'd0);
        press_mode(2'd1);
        press_mode(2'd2);
        press_mode(2'd3);

        // SET_MIN: three inc presses, then idle; no ticks, blink every 5 edges.
        press_mode(2'd0);
        press_mode(2'd1);
        repeat (3) press_inc(2'd2);
        repeat (26) step_model(2'd2, 3'b000);

        // Back to RUN, then into SET_HR for the simultaneous press.
        press_mode(2'd2);
        press_mode(2'd3);
        press_mode(2'd0);
        btn_mode = 1'b1;
        btn_inc  = 1'b1;
        step_model(2'd1, 3'b000);
        step_model(2'd1, 3'b000);
        @(negedge clk);
        since = 0;
        check("simul_mode", mode, 2'd2);
        check("simul_hr", {1'b0, hr_inc}, 2'b00);
        check("simul_blink", {1'b0, blink}, 2'b01);
        step_model(2'd2, 3'b000);
        step_model(2'd2, 3'b000);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        repeat (3) step_model(2'd2, 3'b000);

        // Leave SET_SEC: first tick exactly 10 edges after the mode=00 edge.
        press_mode(2'd2);
        press_mode(2'd3);
        repeat (12) step_model(2'd0, 3'b000);

        // Async reset mid-cycle in SET_SEC with blink high.
        press_mode(2'd0);
        press_mode(2'd1);
        press_mode(2'd2);
        repeat (5) step_model(2'd3, 3'b000);
        #2;
        reset    = 1'b0;
        btn_mode = 1'b1;
        #1;
        check("async_mode", mode, 2'b00);
        check("async_blink", {1'b0, blink}, 2'b00);
        check("async_sec", {1'b0, sec_inc}, 2'b00);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        since = 0;
        // Held button seen as a fresh press; advance at the 3rd posedge.
        step_model(2'd0, 3'b000);
        step_model(2'd0, 3'b000);
        @(negedge clk);
        check("rel_mode", mode, 2'b01);
        check("rel_blink", {1'b0, blink}, 2'b01);
        btn_mode = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
